noc_flit_deserializer_rx: RTL
=============================

Name: noc_flit_deserializer_rx

Overview:
- Receive end of the router's rtr-to-rtr flit link. Consumes data/dest/is_tail/send flits from a router output port and returns credits.
- Reassembles SERIALIZATION_FACTOR flits into one AXI-Stream beat and drives an AXIS master.
- Single-clock endpoint in the clk_noc domain, for endpoints that attach directly to a router port without the dual-clock shim.

Parameters:
- TDATA_WIDTH, 32, AXIS data width.
- TDEST_WIDTH, 4, AXIS tdest width.
- TID_WIDTH, 2, AXIS tid width.
- SERIALIZATION_FACTOR, 2, flits per AXIS beat (>=1; must divide TDATA_WIDTH).
- FLIT_BUFFER_DEPTH, 8, receive FIFO depth in flits; equals the credit count the upstream holds after reset.
- FLIT_WIDTH, TDATA_WIDTH/SERIALIZATION_FACTOR, flit payload width.
- DEST_WIDTH, TDEST_WIDTH+TID_WIDTH, flit dest field width.

Ports:
- clk_noc  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- data_in  in  FLIT_WIDTH  flit payload.
- dest_in  in  DEST_WIDTH  flit destination, {tid,tdest}.
- is_tail_in  in  1  last flit of packet.
- send_in  in  1  flit valid this cycle; no ready, credit-governed.
- credit_out  out  1  one-cycle pulse per freed FIFO slot.
- axis_out_tvalid  out  1  AXIS valid.
- axis_out_tready  in  1  AXIS ready.
- axis_out_tdata  out  TDATA_WIDTH  assembled beat.
- axis_out_tlast  out  1  packet end.
- axis_out_tid  out  TID_WIDTH  dest_in[DEST_WIDTH-1:TDEST_WIDTH] of first flit of beat.
- axis_out_tdest  out  TDEST_WIDTH  dest_in[TDEST_WIDTH-1:0] of first flit of beat.
- overflow_err  out  1  sticky: a flit arrived with FIFO full.
- dest_err  out  1  sticky dest-mismatch flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk_noc edge):
  - FIFO emptied; beat counter cleared to 0; partial assembly discarded.
  - All outputs 0: axis_out_* = 0, credit_out = 0, overflow_err = 0, dest_err = 0.
  - No credits are emitted for flits discarded by reset; the upstream resets in the same reset domain.
- Receive FIFO:
  - FLIT_BUFFER_DEPTH entries of {data, dest, is_tail}, first-word fall-through.
  - Write when send_in=1 and FIFO not full.
  - send_in=1 while full: flit dropped, overflow_err set. Simultaneous pop and write when full is a legal write.
- Beat counter cnt, 0..SERIALIZATION_FACTOR-1.
  - A head flit is final-of-beat if cnt==SERIALIZATION_FACTOR-1 or its is_tail=1.
- Pop condition: FIFO non-empty AND (head is not final-of-beat OR !axis_out_tvalid OR axis_out_tready).
- On pop of a non-final flit:
  - Stored into assembly slice [cnt*FLIT_WIDTH +: FLIT_WIDTH], flit 0 = LSBs.
  - cnt==0 also captures dest.
  - cnt increments.
- On pop of the final-of-beat flit:
  - Output register loads the assembly plus this flit. Unfilled upper slices (early tail) are 0.
  - tlast = is_tail of this flit. tid/tdest come from the dest captured at cnt==0; if cnt==0, from this flit.
  - axis_out_tvalid=1; cnt returns to 0; assembly cleared.
- AXIS rules:
  - tvalid/tdata/tlast/tid/tdest stay stable while tvalid=1 and tready=0.
  - tvalid drops after a handshake unless a new beat loads in the same cycle.
- credit_out: registered; pulses 1 the cycle after each pop. One pop per cycle max, so at most one credit per cycle.
- Latency:
  - send_in at cycle t → flit at FIFO head at t+1.
  - SERIALIZATION_FACTOR=1: tvalid at t+2, credit_out at t+2.
- Throughput: sustained 1 flit/cycle with tready held high.
- dest_in is meaningful only on the first flit of a beat; later flits' dest is ignored (unless the Optional Feature is compiled in).

Optional Feature:
- Macro NOC_DESER_DEST_CHECK_EN.
- Defined: each non-first flit of a beat has its dest compared to the captured dest. A mismatch sets dest_err (sticky until reset). Data path is unaffected.
- Undefined: no comparator; dest_err tied to 0.

Test Plan:
1. SER=2. Flit 0x1111 (dest 6'b10_0101, tail 0), then flit 0x2222 (tail 1), tready=1 → one beat: tdata=0x22221111, tlast=1, tid=2, tdest=5. Two credit_out pulses.
2. SER=2, tready=0. Send 8 back-to-back flits, no tails → 3 credits returned (1 beat in output register, 1 flit in assembly), 5 flits held in FIFO. Raise tready → 4 beats in order, 5 further credits, total credits 8.
3. Single flit 0xABCD with tail=1, SER=2 → tdata=0x0000ABCD, tlast=1, 1 credit.
4. tready=0; upstream ignores credits and sends 12 flits → first 11 accepted (3 popped + 8 in FIFO). overflow_err=1 from the cycle after the 12th flit. Drain yields flits 1..11 intact.
5. Reset mid-beat: after first flit of a SER=2 beat, hold rst_n=0 for 1 cycle → all outputs 0. Next two flits 0x3333/0x4444 form a fresh beat 0x44443333.
6. With NOC_DESER_DEST_CHECK_EN defined: beat flits with dest 5 then 6 → dest_err=1 and beat still delivered. Without the macro, the same stimulus leaves dest_err=0.

Source files
------------

// File: rtl/noc_flit_deserializer_rx.sv
// Router-port flit receiver: buffers credit-governed flits and reassembles
// SERIALIZATION_FACTOR flits per AXI-Stream beat. Optional macro: NOC_DESER_DEST_CHECK_EN.
module noc_flit_deserializer_rx #(
    parameter int TDATA_WIDTH          = 32,
    parameter int TDEST_WIDTH          = 4,
    parameter int TID_WIDTH            = 2,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_BUFFER_DEPTH    = 8,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH
) (
    input  logic                   clk_noc,
    input  logic                   rst_n,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic                   overflow_err,
    output logic                   dest_err
);

    localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam int PTR_W   = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int BEAT_W  = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FLIT_BUFFER_DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SERIALIZATION_FACTOR - 1);

    logic [ENTRY_W-1:0]     r_mem [FLIT_BUFFER_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [BEAT_W-1:0]      r_beat;
    logic [TDATA_WIDTH-1:0] r_asm;
    logic [DEST_WIDTH-1:0]  r_cap_dest;

    logic                   r_tvalid;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic                   r_tlast;
    logic [TID_WIDTH-1:0]   r_tid;
    logic [TDEST_WIDTH-1:0] r_tdest;
    logic                   r_credit;
    logic                   r_overflow;

    logic                   w_empty;
    logic                   w_full;
    logic [FLIT_WIDTH-1:0]  w_head_data;
    logic [DEST_WIDTH-1:0]  w_head_dest;
    logic                   w_head_tail;
    logic                   w_final;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_ovf;
    logic [TDATA_WIDTH-1:0] w_beat_data;
    logic [DEST_WIDTH-1:0]  w_beat_dest;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FIFO_FULL);
    assign {w_head_tail, w_head_dest, w_head_data} = r_mem[r_rd_ptr];

    // A beat closes on the last slice or on an early tail; only closing flits wait on AXIS.
    assign w_final = (r_beat == BEAT_LAST) || w_head_tail;
    assign w_pop   = !w_empty && (!w_final || !r_tvalid || axis_out_tready);
    assign w_wr    = send_in && (!w_full || w_pop);
    assign w_ovf   = send_in && w_full && !w_pop;

    assign w_beat_dest = (r_beat == '0) ? w_head_dest : r_cap_dest;

    always_comb begin
        w_beat_data = r_asm;
        w_beat_data[int'(r_beat)*FLIT_WIDTH +: FLIT_WIDTH] = w_head_data;
    end

    always_ff @(posedge clk_noc) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {is_tail_in, dest_in, data_in};
        end
    end

    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_beat     <= '0;
            r_asm      <= '0;
            r_cap_dest <= '0;
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
            r_tid      <= '0;
            r_tdest    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            r_credit <= w_pop;
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end

            if (w_pop && !w_final) begin
                r_asm  <= w_beat_data;
                r_beat <= r_beat + 1'b1;
                if (r_beat == '0) begin
                    r_cap_dest <= w_head_dest;
                end
            end

            // Output register reloads only when empty or being consumed, so it holds under backpressure.
            if (w_pop && w_final) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_beat_data;
                r_tlast  <= w_head_tail;
                r_tid    <= w_beat_dest[DEST_WIDTH-1:TDEST_WIDTH];
                r_tdest  <= w_beat_dest[TDEST_WIDTH-1:0];
                r_beat   <= '0;
                r_asm    <= '0;
            end else if (axis_out_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

`ifdef NOC_DESER_DEST_CHECK_EN
    logic r_dest_err;

    always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
            r_dest_err <= 1'b0;
        end else if (w_pop && (r_beat != '0) && (w_head_dest != r_cap_dest)) begin
            r_dest_err <= 1'b1;
        end
    end

    assign dest_err = r_dest_err;
`else
    assign dest_err = 1'b0;
`endif

    assign credit_out      = r_credit;
    assign axis_out_tvalid = r_tvalid;
    assign axis_out_tdata  = r_tdata;
    assign axis_out_tlast  = r_tlast;
    assign axis_out_tid    = r_tid;
    assign axis_out_tdest  = r_tdest;
    assign overflow_err    = r_overflow;

endmodule
